// File: rtl/poco_dmem_io_if.sv
// Data-side bus between the POCO core and its memory/I-O responder,
// bundled with the TX FIFO valid/ready output stream.
interface poco_dmem_io_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] ddataout;
    logic              we;
    logic [DATA_W-1:0] ddatain;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output daddr,
        output ddataout,
        output we,
        output tx_ready,
        input  ddatain,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  daddr,
        input  ddataout,
        input  we,
        input  tx_ready,
        output ddatain,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/poco_dmem_io.sv
// POCO data-side responder: word RAM plus memory-mapped TX FIFO, STATUS and
// an optional cycle counter (enabled by defining POCO_DMEM_CYCCNT_EN).
module poco_dmem_io #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    poco_dmem_io_if.slave    bus
);

    localparam int RAM_DEPTH  = 2 ** ADDR_W;
    localparam int FIFO_DEPTH = 2 ** FIFO_AW;

    localparam logic [DATA_W-1:0]  ADDR_TXDATA = DATA_W'(16'h8000);
    localparam logic [DATA_W-1:0]  ADDR_STATUS = DATA_W'(16'h8001);
    localparam logic [DATA_W-1:0]  ADDR_CYCCNT = DATA_W'(16'h8002);
    localparam logic [FIFO_AW:0]   COUNT_FULL  = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_ram     [RAM_DEPTH];
    logic [DATA_W-1:0]  r_fifoMem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wrPtr;
    logic [FIFO_AW-1:0] r_rdPtr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    logic               w_isRam;
    logic               w_ramWr;
    logic               w_push;
    logic               w_pop;
    logic               w_pushAcc;
    logic               w_pushDrop;
    logic               w_ovfClr;
    logic               w_empty;
    logic               w_full;
    logic               w_txValid;
    logic [7:0]         w_count8;
    logic [DATA_W-1:0]  w_ramRd;
    logic [DATA_W-1:0]  w_status;
    logic [DATA_W-1:0]  w_cycRd;
    logic [DATA_W-1:0]  w_rdData;

    assign w_isRam    = ~bus.daddr[DATA_W-1];
    assign w_ramWr    = bus.we & w_isRam;
    assign w_push     = bus.we & (bus.daddr == ADDR_TXDATA);
    assign w_ovfClr   = bus.we & (bus.daddr == ADDR_STATUS) & bus.ddataout[2];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == COUNT_FULL);
    assign w_txValid  = ~w_empty;
    assign w_pop      = w_txValid & bus.tx_ready;

    // A full FIFO can still take a word if the head leaves in the same cycle.
    assign w_pushAcc  = w_push & (~w_full | w_pop);
    assign w_pushDrop = w_push & w_full & ~w_pop;

    // Upper index bits are ignored, so the RAM aliases across the low half of the map.
    assign w_ramRd    = r_ram[bus.daddr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_ramWr) begin
            r_ram[bus.daddr[ADDR_W-1:0]] <= bus.ddataout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_pushAcc) begin
            r_fifoMem[r_wrPtr] <= bus.ddataout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + FIFO_AW'(1);
            end
            case ({w_pushAcc, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_pushDrop) begin
            r_ovf <= 1'b1;
        end else if (w_ovfClr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef POCO_DMEM_CYCCNT_EN
    logic [DATA_W-1:0] r_cycCnt;
    logic              w_cycWr;

    assign w_cycWr = bus.we & (bus.daddr == ADDR_CYCCNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycCnt <= '0;
        end else if (w_cycWr) begin
            r_cycCnt <= bus.ddataout;
        end else begin
            r_cycCnt <= r_cycCnt + DATA_W'(1);
        end
    end

    assign w_cycRd = r_cycCnt;
`else
    assign w_cycRd = '0;
`endif

    assign w_count8 = 8'(r_count);
    assign w_status = DATA_W'({w_count8, 5'b00000, r_ovf, w_full, w_empty});

    // TXDATA and every unmapped I/O address read back as zero.
    always_comb begin
        w_rdData = '0;
        if (w_isRam) begin
            w_rdData = w_ramRd;
        end else if (bus.daddr == ADDR_STATUS) begin
            w_rdData = w_status;
        end else if (bus.daddr == ADDR_CYCCNT) begin
            w_rdData = w_cycRd;
        end
    end

    assign bus.ddatain  = w_rdData;
    assign bus.tx_data  = r_fifoMem[r_rdPtr];
    assign bus.tx_valid = w_txValid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= COUNT_FULL);
            assert ((r_wrPtr - r_rdPtr) == r_count[FIFO_AW-1:0]);
        end
    end

endmodule

// File: tb/tb_poco_dmem_io.sv
// Self-checking bench for poco_dmem_io: directed vector table, hand-written
// FIFO/reset/counter sequences and a randomized run against a queue model.
module tb_poco_dmem_io;

    localparam int DEPTH = 8;
`ifdef POCO_DMEM_CYCCNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poco_dmem_io_if #(.DATA_W(16)) busIf ();

    poco_dmem_io #(
        .DATA_W  (16),
        .ADDR_W  (10),
        .FIFO_AW (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        ready;
        bit          chkRd;
        logic [15:0] expRd;
        logic        expValid;
        bit          chkTx;
        logic [15:0] expTx;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference state for the randomized run.
    logic [15:0] qM[$];
    bit          ovfM;
    logic [15:0] cycM;
    logic [15:0] ramM[1024];
    int          knownIdx[$];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d, input logic r);
        busIf.we       = w;
        busIf.daddr    = a;
        busIf.ddataout = d;
        busIf.tx_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic w, input logic [15:0] a, input logic [15:0] d,
                                   input logic r, input bit cRd, input logic [15:0] eRd,
                                   input logic eV, input bit cTx, input logic [15:0] eTx);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.ready = r;
        v.chkRd = cRd; v.expRd = eRd; v.expValid = eV; v.chkTx = cTx; v.expTx = eTx;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] modelRead(input logic [15:0] a);
        logic [7:0] cnt;
        cnt = 8'(qM.size());
        if (!a[15])          return ramM[a[9:0]];
        if (a == 16'h8001)   return {cnt, 5'b0, ovfM, qM.size() == DEPTH, qM.size() == 0};
        if (a == 16'h8002)   return CYC_EN ? cycM : 16'h0000;
        return 16'h0000;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp16;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Directed table: reset state, RAM with alias, FIFO fill/overflow, drain, ovf clear.
        addVec(0, 16'h8001, 16'h0000, 0, 1, 16'h0001, 0, 0, 16'h0000);
        addVec(1, 16'h0005, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000);
        addVec(1, 16'h03FF, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000);
        addVec(0, 16'h0005, 16'h0000, 0, 1, 16'h1234, 0, 0, 16'h0000);
        addVec(0, 16'h43FF, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0000);
        addVec(0, 16'h8003, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000);
        addVec(0, 16'h8000, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000);
        for (int i = 1; i <= 8; i++)
            addVec(1, 16'h8000, 16'(i), 0, 1, 16'h0000, i > 1, i > 1, 16'h0001);
        addVec(0, 16'h8001, 16'h0000, 0, 1, 16'h0802, 1, 1, 16'h0001);
        addVec(1, 16'h8000, 16'h0009, 0, 1, 16'h0000, 1, 1, 16'h0001);
        addVec(0, 16'h8001, 16'h0000, 0, 1, 16'h0806, 1, 1, 16'h0001);
        for (int i = 1; i <= 8; i++)
            addVec(0, 16'h8001, 16'h0000, 1, 1,
                   {8'(9 - i), 8'h0} | ((i == 1) ? 16'h0006 : 16'h0004), 1, 1, 16'(i));
        addVec(0, 16'h8001, 16'h0000, 1, 1, 16'h0005, 0, 0, 16'h0000);
        addVec(1, 16'h8001, 16'h0004, 0, 1, 16'h0005, 0, 0, 16'h0000);
        addVec(0, 16'h8001, 16'h0000, 0, 1, 16'h0001, 0, 0, 16'h0000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
            #1;
            if (vecs[i].chkRd) checkOutput($sformatf("vec%0d ddatain", i), busIf.ddatain, vecs[i].expRd);
            checkOutput($sformatf("vec%0d tx_valid", i), {15'b0, busIf.tx_valid}, {15'b0, vecs[i].expValid});
            if (vecs[i].chkTx) checkOutput($sformatf("vec%0d tx_data", i), busIf.tx_data, vecs[i].expTx);
            tick();
        end

        // Full FIFO with a simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h8000, 16'h0010 + 16'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 16'h8000, 16'h00AA, 1'b1);
        #1;
        checkOutput("t4 head before", busIf.tx_data, 16'h0010);
        tick();
        applyStimulus(1'b0, 16'h8001, 16'h0000, 1'b0);
        #1;
        checkOutput("t4 status", busIf.ddatain, 16'h0802);
        applyStimulus(1'b0, 16'h8001, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            exp16 = (i < 7) ? 16'h0011 + 16'(i) : 16'h00AA;
            checkOutput($sformatf("t4 drain%0d", i), busIf.tx_data, exp16);
            tick();
        end
        #1;
        checkOutput("t4 valid end", {15'b0, busIf.tx_valid}, 16'h0000);
        checkOutput("t4 status end", busIf.ddatain, 16'h0001);

        // Reset in the middle of a queued stream keeps RAM contents.
        applyStimulus(1'b1, 16'h0100, 16'h5A5A, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h8000, 16'h0020 + 16'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h8001, 16'h0000, 1'b0);
        #1;
        checkOutput("t5 status pre", busIf.ddatain, 16'h0300);
        applyStimulus(1'b0, 16'h8001, 16'h0000, 1'b1);
        doReset();
        applyStimulus(1'b0, 16'h8001, 16'h0000, 1'b0);
        #1;
        checkOutput("t5 valid", {15'b0, busIf.tx_valid}, 16'h0000);
        checkOutput("t5 status", busIf.ddatain, 16'h0001);
        busIf.daddr = 16'h0100;
        #1;
        checkOutput("t5 ram kept", busIf.ddatain, 16'h5A5A);

        // Cycle counter: counts from reset, then reloads and wraps.
        doReset();
        applyStimulus(1'b0, 16'h8002, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("t6 count%0d", i), busIf.ddatain, CYC_EN ? 16'(i) : 16'h0000);
            tick();
        end
        applyStimulus(1'b1, 16'h8002, 16'hFFFE, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h8002, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("t6 wrap%0d", i), busIf.ddatain,
                        CYC_EN ? 16'hFFFE + 16'(i) : 16'h0000);
            tick();
        end

        // Randomized traffic against the queue-based reference.
        doReset();
        qM.delete();
        ovfM = 1'b0;
        cycM = 16'h0000;
        for (int n = 0; n < 600; n++) begin
            int          op;
            logic        w, r, popM, fullM;
            logic [15:0] a, d;
            op = $urandom_range(0, 7);
            r  = ($urandom_range(0, 3) == 0);
            w  = 1'b0;
            d  = 16'($urandom());
            a  = 16'h8003;
            case (op)
                0: begin w = 1'b1; a = {1'b0, 5'($urandom()), 10'($urandom())}; end
                1: if (knownIdx.size() > 0)
                       a = {1'b0, 5'($urandom()), 10'(knownIdx[$urandom_range(0, knownIdx.size() - 1)])};
                2, 3: begin w = 1'b1; a = 16'h8000; end
                4: a = 16'h8001;
                5: begin w = 1'b1; a = 16'h8001; end
                6: begin a = 16'h8002; w = ($urandom_range(0, 3) == 0); end
                default: a = 16'h8003 + 16'($urandom_range(0, 16'h7FFC));
            endcase
            applyStimulus(w, a, d, r);
            #1;
            checkOutput("rnd tx_valid", {15'b0, busIf.tx_valid}, {15'b0, qM.size() != 0});
            if (qM.size() != 0) checkOutput("rnd tx_data", busIf.tx_data, qM[0]);
            if (!w) checkOutput($sformatf("rnd read 0x%04h", a), busIf.ddatain, modelRead(a));

            fullM = (qM.size() == DEPTH);
            popM  = (qM.size() != 0) && r;
            if (popM) void'(qM.pop_front());
            if (w && a == 16'h8000) begin
                if (!fullM || popM) qM.push_back(d);
                else ovfM = 1'b1;
            end
            if (w && a == 16'h8001 && d[2]) ovfM = 1'b0;
            if (w && !a[15]) begin
                ramM[a[9:0]] = d;
                knownIdx.push_back(int'(a[9:0]));
            end
            cycM = (w && a == 16'h8002) ? d : cycM + 16'h0001;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
